fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO between `NUM_REQ` producers. Each producer holds a request with its data word. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words. It drives the FIFO `wr_en`/`data_in` from registers and throttles on `full`/`almostfull`, so the FIFO never overflows. It sits directly in front of the FIFO write side. The read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of producers, 2..8.
- `FIFO_WIDTH`, default 16: data word width; equals the FIFO data width.
- `MAX_BURST`, default 4: maximum words accepted per grant, 1..15.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: per-producer request; producer holds `req`/`data` stable until acked.
- `data` input NUM_REQ*FIFO_WIDTH: producer i owns bits `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `ack` output NUM_REQ: combinational, one-hot or zero.
  - `ack[i]`=1 means producer i's word is accepted this cycle.
  - The producer presents its next word, or drops `req`, after the edge.
- `fifo_full` input 1: FIFO `full`.
- `fifo_almostfull` input 1: FIFO `almostfull` (one slot left).
- `fifo_wr_en` output 1: registered FIFO write enable.
- `fifo_data_in` output FIFO_WIDTH: registered FIFO write data.
- `owner` output clog2(NUM_REQ): registered index of the current grant holder.
- `busy` output 1: registered; 1 while in state GRANT.

## Operation
- **States:** IDLE, GRANT. Reset state is IDLE.
- **Priority pointer `ptr`** (reset 0): search order is `ptr`, `ptr+1`, … modulo NUM_REQ.
- **IDLE:**
  - If any `req` is set, select the first requester in search order.
  - Next edge: `owner`<=winner, `burst_cnt`<=0, state<=GRANT.
  - No ack is issued in IDLE. This gives a one-cycle arbitration bubble.
- **Write-safe condition:** `space_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en)`. The registered write in flight consumes the last slot.
- **GRANT, accept rule:** accept when `req[owner] && space_ok`.
  - On accept: `ack[owner]`=1.
  - Next edge: `fifo_wr_en`<=1, `fifo_data_in`<=`data[owner]`, `burst_cnt`++.
  - Otherwise, next edge: `fifo_wr_en`<=0 and `fifo_data_in` holds its value.
- **GRANT, release rule.** Go to IDLE at the next edge when either:
  - an accept happens with `burst_cnt == MAX_BURST-1`, or
  - `req[owner]` is 0.
- **On release:** `ptr`<=`owner+1` (wrap to 0 after NUM_REQ-1).
- **Stall:** when `!space_ok` with `req[owner]`=1, stay in GRANT. `burst_cnt` is frozen and there is no ack. No timeout.
- **Request changes during a grant:**
  - A non-owner raising `req` has no effect until the next arbitration.
  - The owner dropping `req` mid-burst releases the grant; no word is lost.
- **`burst_cnt` width:** 4 bits.
- **Reset (async, any time):**
  - state=IDLE, `ptr`=0, `owner`=0, `burst_cnt`=0.
  - `fifo_wr_en`=0, `fifo_data_in`=0, `busy`=0, `ack`=0.
  - A write in flight at reset is discarded.

## Timing
- Request to first ack: 1 cycle (IDLE arbitration edge). The ack comes in the following cycle if `space_ok`.
- Ack to FIFO write: `fifo_wr_en`/`fifo_data_in` asserted the cycle after the ack and sampled by the FIFO at the next edge.
- Throughput:
  - At most 1 word/cycle within a burst.
  - Burst of B words with no stall: B+1 cycles including the arbitration cycle.
- Full path: `fifo_full` and `fifo_almostfull` feed `ack` combinationally. No flop between FIFO flags and `ack`.
- Burst end to next grant: the cycle after the release edge is an IDLE arbitration cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-burst.
  - Required: outputs zero immediately (asynchronously), no `fifo_wr_en` after release, first grant after reset goes to requester 0.
- **Round-robin:** `req`=4'b1111 held, MAX_BURST=4, FIFO never full.
  - Required: `owner` sequence 0,1,2,3,0.
  - Required: each grant gives exactly 4 acks on consecutive cycles, with 1 idle cycle between bursts.
- **Short request:** producer 2 alone writes 2 words (0xA5A5, 0x5A5A) then drops `req`.
  - Required: 2 acks, FIFO receives 0xA5A5 then 0x5A5A, release to IDLE, `ptr`=3.
- **Almost-full throttle:** FIFO has 2 free slots; producer 1 requests continuously.
  - Required: exactly 2 acks, then `ack`=0 while `fifo_full`=1.
  - Required: no overflow; acks resume the cycle after `full` deasserts.
- **Non-owner request mid-burst:** producer 3 raises `req` during producer 0's burst.
  - Required: no ack to 3 until 0 releases; 3 is granted next (`ptr`=1 scan finds 3 first if 1 and 2 are idle).
- **Data integrity:** random `req`/`data` over 1000 cycles.
  - Scoreboard check: the FIFO write sequence equals the concatenation of acked words in ack order.
  - Scoreboard check: `ack` is never multi-hot, and the FIFO never overflows.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Grants bursts of up to MAX_BURST words and throttles on FIFO full/almostfull.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_d, winner;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic                    wr_en_d, busy_d, any_req;
  logic                    space_ok, accept, last_word;
  logic [FIFO_WIDTH-1:0]   data_in_d;
  logic [FIFO_WIDTH-1:0]   data_arr [NUM_REQ];

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    return IDX_W'((32'(base) + off) % NUM_REQ);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // First requester at or after ptr, modulo NUM_REQ
  always_comb begin
    winner  = ptr_q;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[wrap_add(ptr_q, i)]) begin
        winner  = wrap_add(ptr_q, i);
        any_req = 1'b1;
      end
    end
  end

  // The registered write still in flight takes the last free slot
  assign space_ok  = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign accept    = (state_q == GRANT) && req[owner] && space_ok;
  assign last_word = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner;
    burst_cnt_d = burst_cnt_q;
    wr_en_d     = 1'b0;
    data_in_d   = fifo_data_in;
    ack         = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          ack[owner]  = 1'b1;
          wr_en_d     = 1'b1;
          data_in_d   = data_arr[owner];
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if ((accept && last_word) || !req[owner]) begin
          state_d = IDLE;
          ptr_d   = wrap_add(owner, 1);
        end
      end
    endcase
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner        <= '0;
      burst_cnt_q  <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner        <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      fifo_wr_en   <= wr_en_d;
      fifo_data_in <= data_in_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: reactive producers, a FIFO stand-in, a
// transaction-level arbiter model and a write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int MB    = 4;
  localparam int DEPTH = 8;
  localparam int PB    = 64;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic           fifo_full, fifo_almostfull, fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [1:0]     owner;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] pbuf [N][PB];
  int           phead [N];
  int           ptail [N];
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] wlog [$];
  int           grants [$];
  logic         rd_en;
  logic         prev_busy;
  logic [N-1:0] last_ack;
  int           ack_cnt;

  // Transaction-level model: who holds the grant and how many words it took
  bit           m_granted;
  int           m_own, m_taken, m_ptr;
  logic         m_wr;
  logic [W-1:0] m_wdata;
  logic         m_take;
  logic [W-1:0] m_take_data;
  logic [N-1:0] s_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_granted = 1'b0;
    m_own     = 0;
    m_taken   = 0;
    m_ptr     = 0;
    m_wr      = 1'b0;
    m_wdata   = '0;
    exp_q.delete();
  endtask

  task automatic model_update();
    bit found;
    if (!m_granted) begin
      m_wr  = 1'b0;
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (!found && s_req[(m_ptr + j) % N]) begin
          found     = 1'b1;
          m_own     = (m_ptr + j) % N;
          m_taken   = 0;
          m_granted = 1'b1;
        end
      end
    end else begin
      m_wr = m_take;
      if (m_take) begin
        m_wdata = m_take_data;
        m_taken++;
      end
      if ((m_take && m_taken == MB) || !s_req[m_own]) begin
        m_granted = 1'b0;
        m_ptr     = (m_own + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]         = (phead[i] != ptail[i]);
      data[i*W +: W] = req[i] ? pbuf[i][phead[i] % PB] : '0;
    end
    fifo_full       = (fifo_q.size() == DEPTH);
    fifo_almostfull = (fifo_q.size() == DEPTH - 1);
  endtask

  task automatic push_word(input int p, input logic [W-1:0] w);
    pbuf[p][ptail[p] % PB] = w;
    ptail[p]++;
  endtask

  task automatic clear_prods();
    for (int i = 0; i < N; i++) phead[i] = ptail[i];
  endtask

  // One cycle: compare at negedge, advance model/environment at posedge, drive after
  task automatic step();
    logic [N-1:0] s_ack, exp_ack;
    logic         s_wr, space;
    logic [W-1:0] s_wdata;
    @(negedge clk);
    s_ack   = ack;
    s_wr    = fifo_wr_en;
    s_wdata = fifo_data_in;
    s_req   = req;
    space       = !fifo_full && !(fifo_almostfull && m_wr);
    m_take      = m_granted && req[m_own] && space;
    m_take_data = data[m_own*W +: W];
    exp_ack = '0;
    if (m_take) exp_ack[m_own] = 1'b1;
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("owner", 32'(owner), 32'(m_own));
    chk("busy", 32'(busy), 32'(m_granted));
    chk("wr_en", 32'(fifo_wr_en), 32'(m_wr));
    chk("data_in", 32'(fifo_data_in), 32'(m_wdata));
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'(1));
    last_ack = s_ack;
    if (s_ack != '0) ack_cnt++;
    if (busy && !prev_busy) grants.push_back(int'(owner));
    prev_busy = busy;
    for (int i = 0; i < N; i++)
      if (s_ack[i] && phead[i] != ptail[i]) exp_q.push_back(pbuf[i][phead[i] % PB]);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    if (s_wr) begin
      chk("no_overflow", 32'(fifo_q.size() < DEPTH), 32'(1));
      chk("sb_pending", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) chk("sb_data", 32'(s_wdata), 32'(exp_q.pop_front()));
      wlog.push_back(s_wdata);
    end
    if (rd_en && fifo_q.size() > 0) fifo_q.delete(0);
    if (s_wr && fifo_q.size() < DEPTH) fifo_q.push_back(s_wdata);
    for (int i = 0; i < N; i++)
      if (s_ack[i] && phead[i] != ptail[i]) phead[i]++;
    #1 drive();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat, exp_pat;
    int          ord [5];
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    rd_en     = 1'b1;
    prev_busy = 1'b0;
    last_ack  = '0;
    ack_cnt   = 0;
    model_reset();
    drive();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("rst_data_in", 32'(fifo_data_in), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    steps(2);

    // Round robin with all four requesting
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 8; k++) push_word(p, W'(p * 256 + k + 1));
    drive();
    grants.delete();
    ack_cnt = 0;
    pat     = '0;
    exp_pat = '0;
    for (int c = 0; c < 25; c++) begin
      step();
      pat[c]     = (last_ack != '0);
      exp_pat[c] = ((c % 5) != 0);
    end
    chk("rr_acks", 32'(ack_cnt), 32'(20));
    chk("rr_pattern", pat, exp_pat);
    ord = '{0, 1, 2, 3, 0};
    chk("rr_grants", 32'(grants.size()), 32'(5));
    if (grants.size() >= 5)
      for (int k = 0; k < 5; k++) chk("rr_owner_seq", 32'(grants[k]), 32'(ord[k]));
    clear_prods();
    drive();
    steps(3);

    // Short request from producer 2
    wlog.delete();
    grants.delete();
    ack_cnt = 0;
    push_word(2, 16'hA5A5);
    push_word(2, 16'h5A5A);
    drive();
    steps(6);
    chk("short_acks", 32'(ack_cnt), 32'(2));
    chk("short_grants", 32'(grants.size()), 32'(1));
    if (grants.size() >= 1) chk("short_owner", 32'(grants[0]), 32'(2));
    chk("short_writes", 32'(wlog.size()), 32'(2));
    if (wlog.size() >= 2) begin
      chk("short_word0", 32'(wlog[0]), 32'(16'hA5A5));
      chk("short_word1", 32'(wlog[1]), 32'(16'h5A5A));
    end
    chk("short_idle", 32'(busy), 32'(0));

    // Pointer now at 3: producer 3 beats producer 0
    grants.delete();
    push_word(0, 16'h0F0F);
    push_word(3, 16'h3333);
    drive();
    steps(8);
    chk("ptr3_grants", 32'(grants.size()), 32'(2));
    if (grants.size() >= 2) begin
      chk("ptr3_first", 32'(grants[0]), 32'(3));
      chk("ptr3_second", 32'(grants[1]), 32'(0));
    end

    // Almost-full throttle with two free slots
    rd_en = 1'b0;
    fifo_q.delete();
    for (int k = 0; k < DEPTH - 2; k++) fifo_q.push_back(16'hDEAD);
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) push_word(1, W'(16'h1000 + k));
    drive();
    steps(8);
    chk("thr_acks", 32'(ack_cnt), 32'(2));
    chk("thr_stalled", 32'(ack), 32'(0));
    rd_en = 1'b1;
    drive();
    step();
    rd_en = 1'b0;
    drive();
    step();
    chk("thr_resume", 32'(last_ack), 32'(4'b0010));
    rd_en = 1'b1;
    drive();
    steps(20);
    chk("thr_total", 32'(ack_cnt), 32'(6));

    // Producer 3 raises req during producer 0's burst
    grants.delete();
    for (int k = 0; k < 6; k++) push_word(0, W'(16'h0A00 + k));
    drive();
    steps(2);
    push_word(3, 16'h3C3C);
    drive();
    steps(14);
    chk("mid_grants", 32'(grants.size() >= 2), 32'(1));
    if (grants.size() >= 2) begin
      chk("mid_first", 32'(grants[0]), 32'(0));
      chk("mid_second", 32'(grants[1]), 32'(3));
    end
    clear_prods();
    drive();
    steps(4);

    // Asynchronous reset in the middle of a burst
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 10; k++) push_word(p, W'(16'hC000 + p * 16 + k));
    drive();
    steps(3);
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_ack", 32'(ack), 32'(0));
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("mid_rst_data_in", 32'(fifo_data_in), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_owner", 32'(owner), 32'(0));
    steps(2);
    rst_n = 1'b1;
    grants.delete();
    steps(3);
    chk("post_rst_grants", 32'(grants.size()), 32'(1));
    if (grants.size() >= 1) chk("post_rst_owner", 32'(grants[0]), 32'(0));
    clear_prods();
    drive();
    steps(6);

    // Random producers and FIFO drain
    for (int c = 0; c < 1000; c++) begin
      for (int p = 0; p < N; p++)
        if (ptail[p] - phead[p] < 4 && $urandom_range(0, 2) == 0) push_word(p, W'($urandom));
      rd_en = 1'($urandom_range(0, 1));
      drive();
      step();
    end
    rd_en = 1'b1;
    drive();
    steps(60);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
